// File: rtl/dec_onehot2bin_pipe_if.sv
// Handshake bundle for the one-hot decoder: upstream one-hot words in, decoded code/error out.
// master = the upstream/downstream environment, slave = the decoder.
interface dec_onehot2bin_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/dec_onehot2bin_pipe.sv
// One-hot (15b) to 4b code decoder with output register + skid entry; latency 1, full throughput.
// in_ready comes from registered state only. DEC_ONEHOT_ERRCNT_EN builds the saturating multi-hot counter.
module dec_onehot2bin_pipe #(
  parameter int CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dec_onehot2bin_pipe_if.slave bus,
  output logic [CNT_W-1:0]     err_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e     state_q, state_d;
  logic [3:0] out_code_q, out_code_d;
  logic       out_err_q, out_err_d;
  logic [3:0] skid_code_q, skid_code_d;
  logic       skid_err_q, skid_err_d;

  logic [3:0] dec_code;
  logic       dec_multi;
  logic       in_rdy;
  logic       out_vld;
  logic       accept;
  logic       emit;

  // Lowest set bit wins; an all-zero word maps to the idle code 15.
  always_comb begin
    dec_code = 4'hF;
    for (int k = 14; k >= 0; k--) begin
      if (bus.in_data[k]) dec_code = 4'(k);
    end
    dec_multi = (bus.in_data & (bus.in_data - 15'd1)) != 15'd0;
  end

  assign in_rdy  = (state_q != FULL);
  assign out_vld = (state_q != EMPTY);
  assign accept  = bus.in_valid & in_rdy;
  assign emit    = out_vld & bus.out_ready;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_code_q;
  assign bus.out_err   = out_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      out_code_q  <= 4'h0;
      out_err_q   <= 1'b0;
      skid_code_q <= 4'h0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_code_q  <= out_code_d;
      out_err_q   <= out_err_d;
      skid_code_q <= skid_code_d;
      skid_err_q  <= skid_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_code_d  = out_code_q;
    out_err_d   = out_err_q;
    skid_code_d = skid_code_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          out_code_d = dec_code;
          out_err_d  = dec_multi;
        end
      end
      ONE: begin
        if (accept && emit) begin
          out_code_d = dec_code;
          out_err_d  = dec_multi;
        end else if (accept) begin
          // OUT is stalled, so the new word parks in the skid entry.
          state_d     = FULL;
          skid_code_d = dec_code;
          skid_err_d  = dec_multi;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_d    = ONE;
          out_code_d = skid_code_q;
          out_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

`ifdef DEC_ONEHOT_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept && dec_multi && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt_o = cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dec_onehot2bin_pipe.sv
// Randomized + directed bench for dec_onehot2bin_pipe against a queue-based reference model.
module tb_dec_onehot2bin_pipe;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic [CNT_W-1:0] err_cnt;

  dec_onehot2bin_pipe_if bus ();

  dec_onehot2bin_pipe #(.CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .err_cnt_o (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] exp_q[$];   // {code, err} of words accepted but not yet emitted
  int         model_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [14:0] w);
    int code;
    code = 15;
    for (int k = 0; k < 15; k++) begin
      if (w[k]) begin
        code = k;
        break;
      end
    end
    return {4'(code), ($countones(w) >= 2)};
  endfunction

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      chk("out", 32'(bus.out_data), 32'(exp_q[0][4:1]));
      chk("out_err", 32'(bus.out_err), 32'(exp_q[0][0]));
    end
    chk("err_cnt", 32'(err_cnt), 32'(model_cnt));
  endtask

  // One clock: check at negedge, drive, then advance the model at posedge.
  task automatic cycle(input logic v, input logic [14:0] w, input logic ordy);
    logic       acc;
    logic       emt;
    logic [4:0] d;
    @(negedge clk);
    check_outputs();
    bus.in_valid  = v;
    bus.in_data   = w;
    bus.out_ready = ordy;
    acc = v && (exp_q.size() < 2);
    emt = ordy && (exp_q.size() > 0);
    d   = ref_decode(w);
    @(posedge clk);
    if (emt) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(d);
`ifdef DEC_ONEHOT_ERRCNT_EN
      if (d[0] && model_cnt < CNT_MAX) model_cnt++;
`endif
    end
  endtask

  function automatic logic [14:0] rand_word();
    logic [14:0] w;
    case ($urandom_range(0, 3))
      0: w = 15'(1) << $urandom_range(0, 14);
      1: w = 15'h0000;
      2: w = (15'(1) << $urandom_range(0, 6)) | (15'(1) << $urandom_range(7, 14));
      default: w = 15'($urandom);
    endcase
    return w;
  endfunction

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 15'h0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out", 32'(bus.out_data), 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'h0);
    check_outputs();
    rst_n = 1'b1;

    // Sweep of all one-hot codes at full rate
    for (int k = 0; k < 15; k++) cycle(1'b1, 15'(1) << k, 1'b1);
    cycle(1'b0, 15'h0, 1'b1);

    // Idle code and a multi-hot word
    cycle(1'b1, 15'h0000, 1'b1);
    cycle(1'b1, 15'h0028, 1'b1);
    cycle(1'b0, 15'h0, 1'b1);

    // Backpressure: 1,2,3 with downstream stalled, then drain
    cycle(1'b1, 15'h0002, 1'b0);
    cycle(1'b1, 15'h0004, 1'b0);
    cycle(1'b1, 15'h0008, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    chk("bp_head", 32'(bus.out_data), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 15'h0008, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 15'h0, 1'b1);

    // Saturation of the multi-hot counter
    for (int i = 0; i < 300; i++) cycle(1'b1, 15'h0028, 1'b1);
    cycle(1'b0, 15'h0, 1'b1);
    @(negedge clk);
`ifdef DEC_ONEHOT_ERRCNT_EN
    chk("err_cnt_sat", 32'(err_cnt), 32'(CNT_MAX));
`else
    chk("err_cnt_off", 32'(err_cnt), 32'h0);
`endif

    // Reset asserted while FULL
    cycle(1'b1, 15'h0100, 1'b0);
    cycle(1'b1, 15'h0200, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("mid_rst_out", 32'(bus.out_data), 32'h0);
    chk("mid_rst_out_err", 32'(bus.out_err), 32'h0);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 15'h0400, 1'b1);
    cycle(1'b0, 15'h0, 1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_word(), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 15'h0, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
